// File: rtl/serial_mac_engine.sv
// Bit-serial loaded multiply-accumulate engine: serial operand load, iterative
// shift-add multiply, signed/unsigned accumulate with saturation and serial readout.
module serial_mac_engine #(
   parameter int unsigned OP_W  = 8,
   parameter int unsigned ACC_W = 20
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             shift_clk,
   input  logic             sin_a,
   input  logic             sin_b,
   input  logic             start,
   input  logic             clear,
   input  logic             signed_mode,
   input  logic             sat_en,
   input  logic             load_res,
   output logic             busy,
   output logic             done,
   output logic [ACC_W-1:0] acc,
   output logic             carry_out,
   output logic             overflow,
   output logic             sout
);

   localparam int unsigned PROD_W = 2 * OP_W;
   localparam int unsigned CNT_W  = $clog2(OP_W + 1);

   if (OP_W < 2) begin : g_bad_op_w
      $error("serial_mac_engine: OP_W must be >= 2");
   end
   if (ACC_W < PROD_W) begin : g_bad_acc_w
      $error("serial_mac_engine: ACC_W must be >= 2*OP_W");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      ACC  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                shift_prev;
   logic                shift_edge_c;
   logic [OP_W-1:0]     opa_sr;
   logic [OP_W-1:0]     opb_sr;
   logic [ACC_W-1:0]    rd_sr;

   logic [PROD_W-1:0]   mcand;
   logic [OP_W-1:0]     mplier;
   logic [PROD_W-1:0]   prod;
   logic [CNT_W-1:0]    cnt;
   logic                sg_q;
   logic                sat_q;

   logic                latch_c;
   logic                step_c;
   logic                acc_wr_c;
   logic                busy_nxt_c;

   logic [PROD_W-1:0]   mcand_init_c;
   logic [PROD_W-1:0]   pp_c;
   logic [PROD_W-1:0]   prod_step_c;
   logic [ACC_W-1:0]    prod_ext_c;
   logic [ACC_W:0]      sum_c;
   logic                ovf_c;
   logic [ACC_W-1:0]    sat_val_c;
   logic [ACC_W-1:0]    acc_nxt_c;

   assign shift_edge_c = shift_clk & ~shift_prev;
   assign sout         = rd_sr[0];

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and control decode; clear overrides everything
   always_comb begin
      state_nxt = state;
      latch_c   = 1'b0;
      step_c    = 1'b0;
      acc_wr_c  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = MUL;
               latch_c   = 1'b1;
            end
         end
         MUL: begin
            if (cnt == CNT_W'(OP_W)) begin
               state_nxt = ACC;
            end else begin
               step_c = 1'b1;
            end
         end
         ACC: begin
            state_nxt = IDLE;
            acc_wr_c  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
      if (clear) begin
         state_nxt = IDLE;
         latch_c   = 1'b0;
         step_c    = 1'b0;
         acc_wr_c  = 1'b0;
      end
      busy_nxt_c = (state_nxt != IDLE);
   end

   // Multiplier datapath: one partial product per cycle, MSB term subtracted when signed
   always_comb begin
      if (signed_mode) begin
         mcand_init_c = PROD_W'($signed(opa_sr));
      end else begin
         mcand_init_c = PROD_W'(opa_sr);
      end
      pp_c = mplier[0] ? mcand : '0;
      if (sg_q && (cnt == CNT_W'(OP_W - 1))) begin
         prod_step_c = prod - pp_c;
      end else begin
         prod_step_c = prod + pp_c;
      end
   end

   // Accumulate: extend product, add with carry bit, detect overflow, saturate
   always_comb begin
      if (sg_q) begin
         prod_ext_c = ACC_W'($signed(prod));
      end else begin
         prod_ext_c = ACC_W'(prod);
      end
      sum_c = {1'b0, acc} + {1'b0, prod_ext_c};
      if (sg_q) begin
         ovf_c = (acc[ACC_W-1] == prod_ext_c[ACC_W-1]) &&
                 (sum_c[ACC_W-1] != acc[ACC_W-1]);
      end else begin
         ovf_c = sum_c[ACC_W];
      end
      if (!sg_q) begin
         sat_val_c = '1;
      end else if (prod_ext_c[ACC_W-1]) begin
         sat_val_c = {1'b1, {(ACC_W-1){1'b0}}};
      end else begin
         sat_val_c = {1'b0, {(ACC_W-1){1'b1}}};
      end
      if (ovf_c && sat_q) begin
         acc_nxt_c = sat_val_c;
      end else begin
         acc_nxt_c = sum_c[ACC_W-1:0];
      end
   end

   // Operation registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcand  <= '0;
         mplier <= '0;
         prod   <= '0;
         cnt    <= '0;
         sg_q   <= 1'b0;
         sat_q  <= 1'b0;
      end else if (latch_c) begin
         mcand  <= mcand_init_c;
         mplier <= opb_sr;
         prod   <= '0;
         cnt    <= '0;
         sg_q   <= signed_mode;
         sat_q  <= sat_en;
      end else if (step_c) begin
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         prod   <= prod_step_c;
         cnt    <= cnt + CNT_W'(1);
      end
   end

   // Accumulator, flags and status outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         busy <= busy_nxt_c;
         done <= acc_wr_c;
         if (clear) begin
            acc       <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
         end else if (acc_wr_c) begin
            acc       <= acc_nxt_c;
            carry_out <= sum_c[ACC_W];
            overflow  <= overflow | ovf_c;
         end
      end
   end

   // Serial operand load and readout; a readout load beats a shift edge
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         shift_prev <= 1'b0;
         opa_sr     <= '0;
         opb_sr     <= '0;
         rd_sr      <= '0;
      end else begin
         shift_prev <= shift_clk;
         if (shift_edge_c) begin
            opa_sr <= {opa_sr[OP_W-2:0], sin_a};
            opb_sr <= {opb_sr[OP_W-2:0], sin_b};
         end
         if (load_res || done) begin
            rd_sr <= acc;
         end else if (shift_edge_c) begin
            rd_sr <= {1'b0, rd_sr[ACC_W-1:1]};
         end
      end
   end

endmodule
